dot_product_sched: RTL
======================

DOT_PRODUCT_SCHED -- requirements
Module: dot_product_sched

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 10: number of weight sets (neurons) evaluated per run.
REQ-002 The block SHALL have parameter DP_LATENCY, default 1: cycles from weights presented on dp_weights to the matching dp_value; legal range 1..8.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: result FIFO entries; minimum 1.
REQ-004 The block SHALL have parameter ADDR_W, default 4: width of w_addr and res_idx, with 2^ADDR_W >= NUM_NEURONS.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port GlobalReset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit: run request, sampled in IDLE only.
REQ-008 The block SHALL have port pixels_in, input, 190 bits: 10 x 19-bit pixels, captured on an accepted start.
REQ-009 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse at run completion.
REQ-011 The block SHALL have ports w_rd_en (output, 1 bit), w_addr (output, ADDR_W bits) and w_rd_data (input, 90 bits): weight memory read; 10 x 9-bit weights, valid exactly 1 cycle after w_rd_en.
REQ-012 The block SHALL have ports dp_pixels (output, 190 bits), dp_weights (output, 90 bits) and dp_value (input, 26 bits): connection to the DotProduct datapath.
REQ-013 The block SHALL have ports res_valid (output, 1 bit), res_ready (input, 1 bit), res_data (output, 26 bits) and res_idx (output, ADDR_W bits): result stream.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-015 In IDLE, start=1 SHALL latch pixels_in into the pixel register, clear issue_cnt, and enter RUN next cycle.
REQ-016 dp_pixels SHALL equal the pixel register at all times, constant for the whole run.
REQ-017 In RUN, an issue SHALL occur in a cycle iff issue_cnt < NUM_NEURONS and (fifo_count + inflight) < FIFO_DEPTH.
REQ-018 An issue SHALL assert w_rd_en=1 with w_addr=issue_cnt and increment issue_cnt; without an issue, w_rd_en=0 and w_addr holds its value.
REQ-019 dp_weights SHALL be driven directly from w_rd_data.
REQ-020 A valid-tag shift register of length 1+DP_LATENCY SHALL carry the issue flag and the index through the pipeline.
REQ-021 When the tag exits the shift register, the block SHALL push {dp_value, index} into the result FIFO in that cycle.
REQ-022 inflight SHALL count issued entries not yet pushed, incrementing on issue and decrementing on push, both in the same cycle when both occur.
REQ-023 The credit rule SHALL guarantee the FIFO never overflows; pushes SHALL never be dropped or stalled.
REQ-024 RUN SHALL transition to DRAIN in the cycle after the last issue (issue_cnt == NUM_NEURONS).
REQ-025 DRAIN SHALL transition to DONE when inflight == 0 and fifo_count == 0.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 The result FIFO SHALL be first-word-fall-through: res_valid = (fifo_count != 0), and res_data/res_idx show the head entry.
REQ-028 A pop SHALL occur when res_valid && res_ready.
REQ-029 A simultaneous push and pop SHALL leave fifo_count unchanged, and results SHALL be delivered in index order 0..NUM_NEURONS-1.
REQ-030 When full (fifo_count == FIFO_DEPTH) with res_ready=0, no issue SHALL occur; issue SHALL resume the cycle after a pop frees a credit.
REQ-031 start in any state other than IDLE SHALL be ignored, and pixels_in SHALL not be re-latched.
REQ-032 NUM_NEURONS=1 SHALL be legal: one issue, then DRAIN, then DONE.
REQ-033 res_data SHALL be dp_value passed unmodified (26-bit, no rounding or saturation).

Reset
REQ-034 While GlobalReset=1, the block SHALL force state IDLE, and busy, done, w_rd_en and res_valid to 0.
REQ-035 While GlobalReset=1, the block SHALL force w_addr, res_idx, res_data, issue_cnt, inflight and fifo_count to 0, clear all valid tags, and set the pixel register (hence dp_pixels) to 0.
REQ-036 Reset asserted mid-run SHALL discard all in-flight and buffered results, and no done pulse SHALL follow.
REQ-037 After GlobalReset deasserts, the first accepted start SHALL occur no earlier than the next rising edge.

Verification
REQ-038 The bench SHALL cover a basic run: all pixels 19'h10000, weights of set n all = n, DP_LATENCY=1, res_ready=1 -> 10 results, idx 0..9 in order, res_data = model dot product, issues on 10 consecutive cycles, done single pulse, busy high from cycle after start until DONE.
REQ-039 The bench SHALL cover backpressure: res_ready=0 throughout -> exactly FIFO_DEPTH issues, then w_rd_en=0 and 4 results held; raising res_ready then completes all 10 in order with none lost or duplicated.
REQ-040 The bench SHALL cover toggling res_ready (1 cycle on, 2 off) with DP_LATENCY=3 -> fifo_count never exceeds FIFO_DEPTH, inflight+fifo_count <= FIFO_DEPTH every cycle, all 10 results correct.
REQ-041 The bench SHALL cover start during a run: start pulsed mid-RUN with different pixels_in -> ignored; results use the original pixels; exactly one done.
REQ-042 The bench SHALL cover reset mid-run: GlobalReset after 5 issues -> all outputs 0 immediately (asynchronous); a new start then produces a clean 10-result run from idx 0.
REQ-043 The bench SHALL cover NUM_NEURONS=1: start -> one w_rd_en at addr 0, one result idx 0, done pulse, return to IDLE.

Source files
------------

// File: rtl/dot_product_sched_if.sv
// Result stream from the scheduler: first-word-fall-through valid/ready with data and index.
interface dot_product_sched_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              res_valid;
    logic              res_ready;
    logic [25:0]       res_data;
    logic [ADDR_W-1:0] res_idx;

    modport master (output res_valid, output res_data, output res_idx, input res_ready);
    modport slave  (input res_valid, input res_data, input res_idx, output res_ready);
endinterface

// File: rtl/dot_product_sched.sv
// Dot-product scheduler: issues one weight-set read per neuron, follows each read through the
// datapath latency with a tag pipeline, and buffers results in a credit-controlled FWFT FIFO.
module dot_product_sched #(
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned DP_LATENCY  = 1,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_W      = 4
) (
    input  logic                clk,
    input  logic                GlobalReset,
    input  logic                start,
    input  logic [189:0]        pixels_in,
    output logic                busy,
    output logic                done,
    output logic                w_rd_en,
    output logic [ADDR_W-1:0]   w_addr,
    input  logic [89:0]         w_rd_data,
    output logic [189:0]        dp_pixels,
    output logic [89:0]         dp_weights,
    input  logic [25:0]         dp_value,
    dot_product_sched_if.master res
);

    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LAST_SLOT = FIFO_DEPTH - 1;
    localparam logic [ADDR_W:0]  LAST_CNT = NUM_NEURONS[ADDR_W:0];
    localparam logic [CNT_W:0]   DEPTH_C  = FIFO_DEPTH[CNT_W:0];
    localparam logic [PTR_W-1:0] LAST_PTR = LAST_SLOT[PTR_W-1:0];

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [189:0]      pixel_q;
    logic [ADDR_W:0]   issue_cnt_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [CNT_W-1:0]  inflight_q, fifo_count_q;
    logic [DP_LATENCY:0] tag_v_q;
    logic [ADDR_W-1:0] tag_idx_q [DP_LATENCY+1];
    logic [25:0]       fifo_data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_idx_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W:0]    credit_used;
    logic              issue, last_issue, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Every entry issued but not yet popped holds a FIFO slot, so pushes can never overflow.
    assign credit_used = {1'b0, fifo_count_q} + {1'b0, inflight_q};
    assign last_issue  = issue && ((issue_cnt_q + 1'b1) == LAST_CNT);
    assign push        = tag_v_q[DP_LATENCY];
    assign pop         = res.res_valid && res.res_ready;

    // State register.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) state_q <= StIdle;
        else             state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_issue) state_d = StDrain;
            StDrain: if (inflight_q == '0 && fifo_count_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and issue decision; w_addr holds its last value between issues.
    always_comb begin
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);
        issue   = (state_q == StRun) && (issue_cnt_q < LAST_CNT) && (credit_used < DEPTH_C);
        w_rd_en = issue;
        w_addr  = issue ? issue_cnt_q[ADDR_W-1:0] : w_addr_q;
    end

    // Pixel capture, issue counter and held read address.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            pixel_q     <= '0;
            issue_cnt_q <= '0;
            w_addr_q    <= '0;
        end else begin
            if (state_q == StIdle && start) begin
                pixel_q     <= pixels_in;
                issue_cnt_q <= '0;
            end else if (issue) begin
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end
            w_addr_q <= w_addr;
        end
    end

    // Tag pipeline: one stage for the weight read plus DP_LATENCY datapath stages.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            tag_v_q <= '0;
            for (int i = 0; i <= int'(DP_LATENCY); i++) tag_idx_q[i] <= '0;
        end else begin
            tag_v_q      <= {tag_v_q[DP_LATENCY-1:0], issue};
            tag_idx_q[0] <= w_addr;
            for (int i = 1; i <= int'(DP_LATENCY); i++) tag_idx_q[i] <= tag_idx_q[i-1];
        end
    end

    // In-flight and FIFO occupancy counters plus FIFO pointers.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            case ({issue, push})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
                2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
                default: fifo_count_q <= fifo_count_q;
            endcase
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // FIFO storage; contents are masked at the outputs while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= dp_value;
            fifo_idx_q[wr_ptr_q]  <= tag_idx_q[DP_LATENCY];
        end
    end

    assign dp_pixels     = pixel_q;
    assign dp_weights    = w_rd_data;
    assign res.res_valid = (fifo_count_q != '0);
    assign res.res_data  = res.res_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign res.res_idx   = res.res_valid ? fifo_idx_q[rd_ptr_q] : '0;

endmodule
